// File: rtl/dlx_mem_pkg.sv
// Shared types and helpers for the DLX multiport memory model and its arbiter.
// Request fields are sized for the widest supported configuration and truncated by the user.
package dlx_mem_pkg;

  localparam int MAX_PORTS  = 8;
  localparam int MAX_ADDR_W = 32;
  localparam int MAX_WORD_W = 64;
  localparam int MAX_BE_W   = MAX_WORD_W / 8;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_state_t;

  typedef struct packed {
    logic [MAX_ADDR_W-1:0] addr;
    logic                  rnw;
    logic [MAX_BE_W-1:0]   be;
    logic [MAX_WORD_W-1:0] wdata;
  } mem_req_t;

  function automatic logic [MAX_WORD_W-1:0] be_merge(
    input logic [MAX_WORD_W-1:0] old_w,
    input logic [MAX_WORD_W-1:0] new_w,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_WORD_W-1:0] res;
    res = old_w;
    for (int b = 0; b < MAX_BE_W; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dlx_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr+1 (mod N).
// Purely combinational; grant is all-zero when grant_en_i is low or nobody requests.
module dlx_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          grant_en_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  int   p;
  logic found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    p       = 0;
    for (int i = 1; i <= N; i++) begin
      p = (int'(ptr_i) + i) % N;
      if (grant_en_i && !found && req_i[p]) begin
        found      = 1'b1;
        grant_o[p] = 1'b1;
        idx_o      = IW'(p);
      end
    end
  end

endmodule

// File: rtl/dlx_multiport_mem.sv
// Multiport word memory: round-robin capture, LATENCY wait states, one-cycle response pulse.
// Requests are held by the requester until DATA_READY; the array itself is never reset.
module dlx_multiport_mem
  import dlx_mem_pkg::*;
#(
  parameter int                   N_PORTS        = 2,
  parameter int                   ADDRESS_SIZE   = 16,
  parameter int                   WORD_SIZE      = 32,
  parameter int                   DEPTH          = 1024,
  parameter int                   LATENCY        = 2,
  parameter logic [MAX_PORTS-1:0] READ_ONLY_MASK = 8'b01,
  parameter string                INIT_FILE      = ""
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_PORTS-1:0]                ENABLE,
  input  logic [N_PORTS-1:0]                READNOTWRITE,
  input  logic [N_PORTS*ADDRESS_SIZE-1:0]   ADDRESS,
  input  logic [N_PORTS*WORD_SIZE/8-1:0]    BYTE_EN,
  input  logic [N_PORTS*WORD_SIZE-1:0]      DATA_IN,
  output logic [N_PORTS*WORD_SIZE-1:0]      DATA_OUT,
  output logic [N_PORTS-1:0]                DATA_READY,
  output logic [N_PORTS-1:0]                ERROR
);

  localparam int BW = WORD_SIZE / 8;
  localparam int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  mem_state_t                   state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [IW-1:0]                ptr_q, ptr_d;
  logic [IW-1:0]                gidx_q, gidx_d;
  mem_req_t                     req_q, req_d;
  logic [N_PORTS*WORD_SIZE-1:0] dout_q, dout_d;
  logic [N_PORTS-1:0]           rdy_q, rdy_d;
  logic [N_PORTS-1:0]           err_q, err_d;

  logic [N_PORTS-1:0]           grant;
  logic [IW-1:0]                gnt_idx;

  logic [WORD_SIZE-1:0]         mem [DEPTH];

  logic                         commit, addr_ok, ro_viol, acc_err, do_write;
  logic [MW-1:0]                midx;
  logic [WORD_SIZE-1:0]         rd_word, wr_word;
  logic [MAX_WORD_W-1:0]        merged;

  dlx_rr_arbiter #(.N(N_PORTS), .IW(IW)) u_arb (
    .req_i      (ENABLE),
    .ptr_i      (ptr_q),
    .grant_en_i (state_q == IDLE),
    .grant_o    (grant),
    .idx_o      (gnt_idx)
  );

  assign commit   = (state_q == BUSY) && (cnt_q == '0);
  assign addr_ok  = req_q.addr < MAX_ADDR_W'(DEPTH);
  assign ro_viol  = !req_q.rnw && READ_ONLY_MASK[gidx_q];
  assign acc_err  = !addr_ok || ro_viol;
  // A reset at the commit edge must leave the array untouched.
  assign do_write = commit && !req_q.rnw && !acc_err && !rst;
  assign midx     = req_q.addr[MW-1:0];
  assign rd_word  = addr_ok ? mem[midx] : '0;
  assign merged   = be_merge(MAX_WORD_W'(rd_word), req_q.wdata, req_q.be);
  assign wr_word  = merged[WORD_SIZE-1:0];

  always_ff @(posedge clk) begin
    if (do_write) mem[midx] <= wr_word;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    req_d   = req_q;
    dout_d  = dout_q;
    rdy_d   = '0;
    err_d   = '0;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          ptr_d       = gnt_idx;
          gidx_d      = gnt_idx;
          cnt_d       = CW'(LATENCY - 1);
          req_d       = '0;
          req_d.addr[ADDRESS_SIZE-1:0] = ADDRESS[gnt_idx*ADDRESS_SIZE +: ADDRESS_SIZE];
          req_d.rnw   = READNOTWRITE[gnt_idx];
          req_d.be[BW-1:0]             = BYTE_EN[gnt_idx*BW +: BW];
          req_d.wdata[WORD_SIZE-1:0]   = DATA_IN[gnt_idx*WORD_SIZE +: WORD_SIZE];
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d        = RESP;
          rdy_d[gidx_q]  = 1'b1;
          err_d[gidx_q]  = acc_err;
          if (req_q.rnw) dout_d[gidx_q*WORD_SIZE +: WORD_SIZE] = rd_word;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= IW'(N_PORTS - 1);
      gidx_q  <= '0;
      req_q   <= '0;
      dout_q  <= '0;
      rdy_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      req_q   <= req_d;
      dout_q  <= dout_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  assign DATA_OUT   = dout_q;
  assign DATA_READY = rdy_q;
  assign ERROR      = err_q;

endmodule

// File: tb/tb_dlx_multiport_mem.sv
// Bench for dlx_multiport_mem: table of single accesses scored through a queue, plus
// reset-abort, arbitration and latency-sweep sequences.
module tb_dlx_multiport_mem;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  en, rnw;
  logic [31:0] addr;
  logic [7:0]  be;
  logic [63:0] din, dout;
  logic [1:0]  rdy, err;

  logic [1:0]  sw_en   [2];
  logic [1:0]  sw_rnw  [2];
  logic [31:0] sw_addr [2];
  logic [7:0]  sw_be   [2];
  logic [63:0] sw_din  [2];
  logic [63:0] sw_dout [2];
  logic [1:0]  sw_rdy  [2];
  logic [1:0]  sw_err  [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          port;
    logic        rd;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    int          port;
    logic        rnw;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;
  vec_t vt[17];

  logic [63:0] exp_dout = '0;
  logic [1:0]  pend     = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dlx_multiport_mem #(.N_PORTS(2), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .ENABLE(en), .READNOTWRITE(rnw), .ADDRESS(addr),
    .BYTE_EN(be), .DATA_IN(din), .DATA_OUT(dout), .DATA_READY(rdy), .ERROR(err)
  );

  dlx_multiport_mem #(.N_PORTS(2), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .ENABLE(sw_en[0]), .READNOTWRITE(sw_rnw[0]), .ADDRESS(sw_addr[0]),
    .BYTE_EN(sw_be[0]), .DATA_IN(sw_din[0]), .DATA_OUT(sw_dout[0]), .DATA_READY(sw_rdy[0]),
    .ERROR(sw_err[0])
  );

  dlx_multiport_mem #(.N_PORTS(2), .LATENCY(5)) dut_l5 (
    .clk(clk), .rst(rst), .ENABLE(sw_en[1]), .READNOTWRITE(sw_rnw[1]), .ADDRESS(sw_addr[1]),
    .BYTE_EN(sw_be[1]), .DATA_IN(sw_din[1]), .DATA_OUT(sw_dout[1]), .DATA_READY(sw_rdy[1]),
    .ERROR(sw_err[1])
  );

  // Scoreboard: every completion pops the oldest expectation; DATA_OUT tracked per slice.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_dout = '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (pend[p] && !en[p]) begin
          errors++;
          $display("FAIL protocol: port %0d dropped ENABLE before completion", p);
        end
        if (rdy[p]) begin
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ready: port %0d pulsed with nothing outstanding", p);
          end else begin
            e = sbq.pop_front();
            if (e.port != p || e.err != err[p]) begin
              errors++;
              $display("FAIL completion: port %0d err %0b, expected port %0d err %0b",
                       p, err[p], e.port, e.err);
            end
            if (e.rd) exp_dout[32*p +: 32] = e.data;
            checks++;
            if (dout !== exp_dout) begin
              errors++;
              $display("FAIL data_out: got %h expected %h", dout, exp_dout);
            end
          end
        end
      end
    end
  end

  task automatic do_op(input int port, input logic r, input logic [15:0] a, input logic [3:0] b,
                       input logic [31:0] wd, input logic [31:0] xd, input logic xe);
    int  n;
    bit  got;
    sbq.push_back('{port, r, xd, xe});
    en = '0;
    en[port]            = 1'b1;
    rnw[port]           = r;
    addr[16*port +: 16] = a;
    be[4*port +: 4]     = b;
    din[32*port +: 32]  = wd;
    pend[port]          = 1'b1;
    n = 0;
    got = 0;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (rdy[port]) got = 1;
    end
    checks++;
    if (!got || n != LAT + 1) begin
      errors++;
      $display("FAIL latency: port %0d addr %h ready after %0d cycles, expected %0d",
               port, a, n, LAT + 1);
    end
    @(posedge clk); #1;
    pend[port] = 1'b0;
    en = '0;
    checks++;
    if (rdy !== 2'b00) begin
      errors++;
      $display("FAIL pulse_width: DATA_READY %b one cycle later, expected 00", rdy);
    end
  endtask

  task automatic sweep_op(input int w, input int lat, input logic r, input logic [31:0] wd,
                          input logic [31:0] xd, output int rdy_cyc);
    int n;
    bit got;
    sw_en[w]          = 2'b10;
    sw_rnw[w]         = {r, 1'b1};
    sw_addr[w][31:16] = 16'h0010;
    sw_be[w][7:4]     = 4'hF;
    sw_din[w][63:32]  = wd;
    n = 0;
    got = 0;
    rdy_cyc = 0;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (sw_rdy[w][1]) got = 1;
    end
    rdy_cyc = cyc;
    checks++;
    if (!got || n != lat + 1 || sw_err[w][1] !== 1'b0) begin
      errors++;
      $display("FAIL sweep_latency: LATENCY=%0d ready after %0d cycles err %b, expected %0d err 0",
               lat, n, sw_err[w][1], lat + 1);
    end
    if (r) begin
      checks++;
      if (sw_dout[w][63:32] !== xd) begin
        errors++;
        $display("FAIL sweep_data: LATENCY=%0d got %h expected %h", lat, sw_dout[w][63:32], xd);
      end
    end
    @(posedge clk); #1;
    sw_en[w] = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, seen;
    int t[4];
    int tw, tr;

    en = '0; rnw = '0; addr = '0; be = '0; din = '0;
    for (int w = 0; w < 2; w++) begin
      sw_en[w] = '0; sw_rnw[w] = '0; sw_addr[w] = '0; sw_be[w] = '0; sw_din[w] = '0;
    end

    vt[0]  = '{1, 1'b0, 16'h0010, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
    vt[1]  = '{1, 1'b1, 16'h0010, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0};
    vt[2]  = '{1, 1'b0, 16'h0010, 4'h5, 32'h11223344, 32'h0,        1'b0};
    vt[3]  = '{1, 1'b1, 16'h0010, 4'h0, 32'h0,        32'hDE22BE44, 1'b0};
    vt[4]  = '{1, 1'b0, 16'h0020, 4'hF, 32'hA5A5A5A5, 32'h0,        1'b0};
    vt[5]  = '{0, 1'b0, 16'h0020, 4'hF, 32'h12345678, 32'h0,        1'b1};
    vt[6]  = '{1, 1'b1, 16'h0020, 4'h0, 32'h0,        32'hA5A5A5A5, 1'b0};
    vt[7]  = '{0, 1'b1, 16'h0020, 4'h0, 32'h0,        32'hA5A5A5A5, 1'b0};
    vt[8]  = '{1, 1'b1, 16'h0400, 4'h0, 32'h0,        32'h0,        1'b1};
    vt[9]  = '{1, 1'b0, 16'h0400, 4'hF, 32'h99999999, 32'h0,        1'b1};
    vt[10] = '{0, 1'b0, 16'h0400, 4'hF, 32'h77777777, 32'h0,        1'b1};
    vt[11] = '{1, 1'b0, 16'h0010, 4'h0, 32'hFFFFFFFF, 32'h0,        1'b0};
    vt[12] = '{1, 1'b1, 16'h0010, 4'h0, 32'h0,        32'hDE22BE44, 1'b0};
    vt[13] = '{1, 1'b0, 16'h03FF, 4'hF, 32'h0F0F0F0F, 32'h0,        1'b0};
    vt[14] = '{0, 1'b1, 16'h03FF, 4'h0, 32'h0,        32'h0F0F0F0F, 1'b0};
    vt[15] = '{1, 1'b0, 16'h0030, 4'hF, 32'h55AA55AA, 32'h0,        1'b0};
    vt[16] = '{0, 1'b1, 16'hFFFF, 4'h0, 32'h0,        32'h0,        1'b1};

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dout !== '0 || rdy !== '0 || err !== '0) begin
      errors++;
      $display("FAIL reset_state: dout %h rdy %b err %b, expected all zero", dout, rdy, err);
    end
    rst = 1'b0;

    for (int i = 0; i < 17; i++)
      do_op(vt[i].port, vt[i].rnw, vt[i].addr, vt[i].be, vt[i].wdata, vt[i].rdata, vt[i].err);

    // Write aborted by reset one edge after capture: no pulse, no commit.
    en = 2'b10; rnw = 2'b00; addr = 32'h0030_0000; be = 8'hF0; din = 64'hCAFEF00D_00000000;
    @(posedge clk); #1;
    rst = 1'b1;
    en  = 2'b00;
    @(posedge clk); #1;
    checks++;
    if (dout !== '0 || rdy !== '0 || err !== '0) begin
      errors++;
      $display("FAIL reset_midop: dout %h rdy %b err %b, expected all zero", dout, rdy, err);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Both ports hold reads from the first post-reset edge.
    for (int k = 0; k < 2; k++) begin
      sbq.push_back('{0, 1'b1, 32'h0F0F0F0F, 1'b0});
      sbq.push_back('{1, 1'b1, 32'hDE22BE44, 1'b0});
    end
    en = 2'b11; rnw = 2'b11; addr = 32'h0010_03FF; be = '0;
    pend = 2'b11;
    n = 0;
    seen = 0;
    while (seen < 4 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (rdy != 2'b00) begin
        t[seen] = n;
        seen++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (seen <= k || t[k] != 3 + 4 * k) begin
        errors++;
        $display("FAIL arbitration_timing: completion %0d at cycle %0d, expected %0d",
                 k, (seen > k) ? t[k] : -1, 3 + 4 * k);
      end
    end
    @(posedge clk); #1;
    pend = 2'b00;
    en   = 2'b00;

    do_op(1, 1'b1, 16'h0030, 4'h0, 32'h0, 32'h55AA55AA, 1'b0);

    sweep_op(0, 1, 1'b0, 32'hDEADBEEF, 32'h0, tw);
    sweep_op(0, 1, 1'b1, 32'h0, 32'hDEADBEEF, tr);
    checks++;
    if (tr - tw != 3) begin
      errors++;
      $display("FAIL sweep_period: LATENCY=1 period %0d, expected 3", tr - tw);
    end
    sweep_op(1, 5, 1'b0, 32'hDEADBEEF, 32'h0, tw);
    sweep_op(1, 5, 1'b1, 32'h0, 32'hDEADBEEF, tr);
    checks++;
    if (tr - tw != 7) begin
      errors++;
      $display("FAIL sweep_period: LATENCY=5 period %0d, expected 7", tr - tw);
    end

    repeat (2) @(posedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d completions outstanding, expected 0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
